aether_mem_arbiter: RTL and testbench

AETHER_MEM_ARBITER -- requirements
Module: aether_mem_arbiter

---
 rtl/aether_mem_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_aether_mem_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aether_mem_arbiter.sv
// -----------------------------------------------------------------------------
// aether_mem_arbiter
//
// Two-requester round-robin arbiter in front of a single generic memory block.
// A granted request is captured, issued to the memory as a one-cycle command,
// then the memory's data streams are routed to the granted requester until
// the memory reports completion (or a BUSY timeout fires). Completion is
// reported back as a one-cycle done pulse with a coincident error flag.
//
// Handshake: req_valid_i[r] is held high with stable cmd/start/end until the
// cycle in which req_ready_o[r] pulses; that pulse is combinational in the
// IDLE cycle and marks the capture edge. Inputs seen after that edge are
// ignored for the captured command and address range.
//
// Ports
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   req_valid_i[1:0]            per-requester task request
//   req_cmd_i[1:0]              per-requester command (0 idle, 1 write,
//                               2 read, 3 illegal)
//   req_start_i / req_end_i     per-requester inclusive address range
//   req_data_write_i            per-requester write data
//   req_ready_o                 capture pulse
//   req_data_read_o / _valid_o  routed read stream (BUSY only)
//   req_data_write_ready_o      routed write-ready (BUSY only)
//   req_done_o / req_err_o      completion pulse and error flag
//   mem_command_o               memory command, one cycle in ISSUE
//   mem_start/end_address_o     captured range, ISSUE through DONE
//   mem_data_write_o            granted write data (BUSY only)
//   mem_data_read_i, mem_data_read_valid_i, mem_data_write_ready_i,
//   mem_task_finished_i         memory status
//   dbg_state_o                 FSM state: 0 IDLE, 1 ISSUE, 2 BUSY, 3 DONE
// -----------------------------------------------------------------------------
module aether_mem_arbiter #(
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 16,
    parameter int TimeoutCycles = 65535
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [1:0]                     req_valid_i,
    input  logic [1:0][1:0]                req_cmd_i,
    input  logic [1:0][AddrWidth-1:0]      req_start_i,
    input  logic [1:0][AddrWidth-1:0]      req_end_i,
    input  logic [1:0][DataWidth-1:0]      req_data_write_i,
    output logic [1:0]                     req_ready_o,
    output logic [1:0][DataWidth-1:0]      req_data_read_o,
    output logic [1:0]                     req_data_read_valid_o,
    output logic [1:0]                     req_data_write_ready_o,
    output logic [1:0]                     req_done_o,
    output logic [1:0]                     req_err_o,
    output logic [1:0]                     mem_command_o,
    output logic [AddrWidth-1:0]           mem_start_address_o,
    output logic [AddrWidth-1:0]           mem_end_address_o,
    output logic [DataWidth-1:0]           mem_data_write_o,
    input  logic [DataWidth-1:0]           mem_data_read_i,
    input  logic                           mem_data_read_valid_i,
    input  logic                           mem_data_write_ready_i,
    input  logic                           mem_task_finished_i,
    output logic [1:0]                     dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Counter holds the number of BUSY cycles already completed; it saturates
    // so that a disabled timeout can never wrap back to the "first cycle" value.
    localparam int CntW    = (TimeoutCycles < 2) ? 1 : $clog2(TimeoutCycles + 1);
    localparam int LastIdx = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;
    localparam logic [CntW-1:0] CntLast = CntW'(LastIdx);
    localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

    state_e                state_q;
    logic                  ptr_q;
    logic                  grant_q;
    logic                  err_q;
    logic [1:0]            cmd_q;
    logic [AddrWidth-1:0]  start_q;
    logic [AddrWidth-1:0]  end_q;
    logic [CntW-1:0]       cnt_q;

    logic                  grant_d;
    logic                  any_valid;
    logic                  legal_d;
    logic                  finish_hit;
    logic                  timeout_hit;

    assign any_valid = |req_valid_i;

    // Pointer only matters on contention; otherwise the lone valid requester wins.
    assign grant_d = (req_valid_i == 2'b11) ? ptr_q : req_valid_i[1];

    assign legal_d = ((req_cmd_i[grant_d] == 2'd1) || (req_cmd_i[grant_d] == 2'd2)) &&
                     (req_start_i[grant_d] <= req_end_i[grant_d]);

    // cnt_q == 0 identifies the first BUSY cycle, in which finish is ignored.
    assign finish_hit  = mem_task_finished_i && (cnt_q != '0);
    assign timeout_hit = (TimeoutCycles != 0) && (cnt_q == CntLast);

    assign dbg_state_o = state_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            grant_q <= 1'b0;
            err_q   <= 1'b0;
            cmd_q   <= 2'd0;
            start_q <= '0;
            end_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_valid) begin
                        grant_q <= grant_d;
                        cmd_q   <= req_cmd_i[grant_d];
                        start_q <= req_start_i[grant_d];
                        end_q   <= req_end_i[grant_d];
                        if (legal_d) begin
                            err_q   <= 1'b0;
                            state_q <= ST_ISSUE;
                        end else begin
                            // Malformed request: report it without touching memory.
                            err_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (cnt_q != CntMax) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    // Finish is checked first so it wins a same-cycle timeout.
                    if (finish_hit) begin
                        err_q   <= 1'b0;
                        state_q <= ST_DONE;
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ptr_q   <= ~grant_q;
                    err_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready_o            = '0;
        req_data_read_o        = '0;
        req_data_read_valid_o  = '0;
        req_data_write_ready_o = '0;
        req_done_o             = '0;
        req_err_o              = '0;
        mem_command_o          = 2'd0;
        mem_start_address_o    = '0;
        mem_end_address_o      = '0;
        mem_data_write_o       = '0;

        // Ready is combinational, so it is gated by reset to keep every
        // output quiet while rst_ni is low.
        if (rst_ni && (state_q == ST_IDLE) && any_valid) begin
            req_ready_o[grant_d] = 1'b1;
        end

        if (state_q != ST_IDLE) begin
            mem_start_address_o = start_q;
            mem_end_address_o   = end_q;
        end

        case (state_q)
            ST_ISSUE: begin
                mem_command_o = cmd_q;
            end
            ST_BUSY: begin
                mem_data_write_o                = req_data_write_i[grant_q];
                req_data_read_o[grant_q]        = mem_data_read_i;
                req_data_read_valid_o[grant_q]  = mem_data_read_valid_i;
                req_data_write_ready_o[grant_q] = mem_data_write_ready_i;
            end
            ST_DONE: begin
                req_done_o[grant_q] = 1'b1;
                req_err_o[grant_q]  = err_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_aether_mem_arbiter.sv
`timescale 1ns/1ps
module tb_aether_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 16;
  localparam int TO = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst_ni = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]          req_valid_i = '0;
  logic [1:0][1:0]     req_cmd_i = '0;
  logic [1:0][AW-1:0]  req_start_i = '0;
  logic [1:0][AW-1:0]  req_end_i = '0;
  logic [1:0][DW-1:0]  req_data_write_i = '0;
  logic [1:0]          req_ready_o;
  logic [1:0][DW-1:0]  req_data_read_o;
  logic [1:0]          req_data_read_valid_o;
  logic [1:0]          req_data_write_ready_o;
  logic [1:0]          req_done_o;
  logic [1:0]          req_err_o;
  logic [1:0]          mem_command_o;
  logic [AW-1:0]       mem_start_address_o;
  logic [AW-1:0]       mem_end_address_o;
  logic [DW-1:0]       mem_data_write_o;
  logic [DW-1:0]       mem_data_read_i = '0;
  logic                mem_data_read_valid_i = 1'b0;
  logic                mem_data_write_ready_i = 1'b0;
  logic                mem_task_finished_i = 1'b0;
  logic [1:0]          dbg_state_o;

  aether_mem_arbiter #(
    .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_cmd_i(req_cmd_i),
    .req_start_i(req_start_i), .req_end_i(req_end_i),
    .req_data_write_i(req_data_write_i),
    .req_ready_o(req_ready_o), .req_data_read_o(req_data_read_o),
    .req_data_read_valid_o(req_data_read_valid_o),
    .req_data_write_ready_o(req_data_write_ready_o),
    .req_done_o(req_done_o), .req_err_o(req_err_o),
    .mem_command_o(mem_command_o),
    .mem_start_address_o(mem_start_address_o), .mem_end_address_o(mem_end_address_o),
    .mem_data_write_o(mem_data_write_o), .mem_data_read_i(mem_data_read_i),
    .mem_data_read_valid_i(mem_data_read_valid_i),
    .mem_data_write_ready_i(mem_data_write_ready_i),
    .mem_task_finished_i(mem_task_finished_i),
    .dbg_state_o(dbg_state_o)
  );

  // scoreboard counters
  int n_cmp = 0;
  int n_bad = 0;

  // pending requests as seen by the requesters, plus the model's pointer
  logic [1:0]    p_valid = '0;
  logic [1:0]    p_cmd [2];
  logic [AW-1:0] p_start [2];
  logic [AW-1:0] p_end [2];
  logic          ptr_m = 1'b0;

  typedef struct {
    logic [1:0]    valid;
    logic [1:0]    cmd0;
    logic [1:0]    cmd1;
    logic [AW-1:0] s0;
    logic [AW-1:0] e0;
    logic [AW-1:0] s1;
    logic [AW-1:0] e1;
    int            fd;
    logic          exp_g;
    logic          exp_legal;
    logic          exp_err;
    int            exp_kend;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check($sformatf("%s/ready", tag), 64'(req_ready_o), 64'd0);
    check($sformatf("%s/rdata", tag), 64'(req_data_read_o), 64'd0);
    check($sformatf("%s/rvalid", tag), 64'(req_data_read_valid_o), 64'd0);
    check($sformatf("%s/wready", tag), 64'(req_data_write_ready_o), 64'd0);
    check($sformatf("%s/done", tag), 64'(req_done_o), 64'd0);
    check($sformatf("%s/err", tag), 64'(req_err_o), 64'd0);
    check($sformatf("%s/mcmd", tag), 64'(mem_command_o), 64'd0);
    check($sformatf("%s/msaddr", tag), 64'(mem_start_address_o), 64'd0);
    check($sformatf("%s/meaddr", tag), 64'(mem_end_address_o), 64'd0);
    check($sformatf("%s/mwdata", tag), 64'(mem_data_write_o), 64'd0);
    check($sformatf("%s/state", tag), 64'(dbg_state_o), 64'd0);
  endtask

  // driver tasks
  task automatic post(input int r, input logic [1:0] cmd, input logic [AW-1:0] s, input logic [AW-1:0] e);
    p_valid[r] = 1'b1;
    p_cmd[r]   = cmd;
    p_start[r] = s;
    p_end[r]   = e;
  endtask

  task automatic post_random(input int r);
    logic [AW-1:0] s;
    p_valid[r] = 1'b1;
    if ($urandom_range(0, 7) < 6) p_cmd[r] = 2'($urandom_range(1, 2));
    else p_cmd[r] = ($urandom_range(0, 1) == 1) ? 2'd3 : 2'd0;
    s = $urandom();
    p_start[r] = s;
    if ($urandom_range(0, 4) != 0) p_end[r] = s + AW'($urandom_range(0, 64));
    else p_end[r] = $urandom();
  endtask

  task automatic drive_pending();
    for (int r = 0; r < 2; r++) begin
      req_valid_i[r] = p_valid[r];
      req_cmd_i[r]   = p_cmd[r];
      req_start_i[r] = p_start[r];
      req_end_i[r]   = p_end[r];
    end
  endtask

  task automatic drive_noise();
    for (int r = 0; r < 2; r++) req_data_write_i[r] = DW'($urandom());
    mem_data_read_i        = DW'($urandom());
    mem_data_read_valid_i  = 1'($urandom());
    mem_data_write_ready_i = 1'($urandom());
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      p_valid = '0;
      drive_pending();
      drive_noise();
      mem_task_finished_i = 1'($urandom());
      #1;
      check_all_zero("idle");
    end
  endtask

  // Reference model: grant by round-robin rule, legality, and BUSY length.
  // fd = first BUSY cycle (1-based) with finish held high, 0 = never.
  function automatic void model(input int fd, output logic g, output logic legal,
                                output logic err, output int kend);
    g = (p_valid == 2'b11) ? ptr_m : p_valid[1];
    legal = ((p_cmd[g] == 2'd1) || (p_cmd[g] == 2'd2)) && (p_start[g] <= p_end[g]);
    if (fd >= 1 && fd <= TO) begin
      kend = (fd < 2) ? 2 : fd;
      err  = 1'b0;
    end else begin
      kend = TO;
      err  = 1'b1;
    end
    if (!legal) begin
      kend = 0;
      err  = 1'b1;
    end
  endfunction

  // One full transaction: accept cycle c=0, then ISSUE/BUSY/DONE (or DONE
  // directly for a rejected request). Checks every output every cycle.
  task automatic serve(input logic g, input logic legal, input logic err,
                       input int kend, input int fd, input string tag);
    logic [1:0]          cmd_c;
    logic [AW-1:0]       s_c;
    logic [AW-1:0]       e_c;
    logic [1:0]          onehot;
    logic [1:0][DW-1:0]  exp_rd;
    logic [1:0]          exp_rdv;
    logic [1:0]          exp_wr;
    logic                in_busy;
    int                  done_c;
    cmd_c  = p_cmd[g];
    s_c    = p_start[g];
    e_c    = p_end[g];
    onehot = 2'b01 << g;
    done_c = legal ? kend + 2 : 1;
    for (int c = 0; c <= done_c; c++) begin
      @(negedge clk);
      if (c >= 1) begin
        // accepted: requester drops valid and its fields wander freely
        p_valid[g] = 1'b0;
        p_cmd[g]   = 2'($urandom());
        p_start[g] = $urandom();
        p_end[g]   = $urandom();
      end
      drive_pending();
      drive_noise();
      mem_task_finished_i = legal && (fd > 0) && (c >= fd + 1);
      #1;
      in_busy = legal && (c >= 2) && (c <= kend + 1);
      exp_rd  = '0;
      exp_rdv = '0;
      exp_wr  = '0;
      if (in_busy) begin
        exp_rd[g]  = mem_data_read_i;
        exp_rdv[g] = mem_data_read_valid_i;
        exp_wr[g]  = mem_data_write_ready_i;
      end
      check($sformatf("%s/c%0d/ready", tag, c), 64'(req_ready_o), (c == 0) ? 64'(onehot) : 64'd0);
      check($sformatf("%s/c%0d/mcmd", tag, c), 64'(mem_command_o), (legal && c == 1) ? 64'(cmd_c) : 64'd0);
      if (legal || c == 0) begin
        check($sformatf("%s/c%0d/msaddr", tag, c), 64'(mem_start_address_o), (c == 0) ? 64'd0 : 64'(s_c));
        check($sformatf("%s/c%0d/meaddr", tag, c), 64'(mem_end_address_o), (c == 0) ? 64'd0 : 64'(e_c));
      end
      check($sformatf("%s/c%0d/mwdata", tag, c), 64'(mem_data_write_o), in_busy ? 64'(req_data_write_i[g]) : 64'd0);
      check($sformatf("%s/c%0d/rdata", tag, c), 64'(req_data_read_o), 64'(exp_rd));
      check($sformatf("%s/c%0d/rvalid", tag, c), 64'(req_data_read_valid_o), 64'(exp_rdv));
      check($sformatf("%s/c%0d/wready", tag, c), 64'(req_data_write_ready_o), 64'(exp_wr));
      check($sformatf("%s/c%0d/done", tag, c), 64'(req_done_o), (c == done_c) ? 64'(onehot) : 64'd0);
      check($sformatf("%s/c%0d/err", tag, c), 64'(req_err_o), (c == done_c && err) ? 64'(onehot) : 64'd0);
    end
    ptr_m = ~g;
  endtask

  initial begin
    logic g;
    logic legal;
    logic err;
    int   kend;
    int   fd;

    for (int r = 0; r < 2; r++) begin
      p_cmd[r] = '0;
      p_start[r] = '0;
      p_end[r] = '0;
    end

    // vectors: valid, cmd0, cmd1, s0, e0, s1, e1, fd, grant, legal, err, busy length
    tbl[0]  = '{2'b01, 2'd1, 2'd0, 0,  3,  0,  0,  6, 1'b0, 1'b1, 1'b0, 6};
    tbl[1]  = '{2'b10, 2'd0, 2'd3, 0,  0,  0,  0,  0, 1'b1, 1'b0, 1'b1, 0};
    tbl[2]  = '{2'b11, 2'd2, 2'd2, 4,  7,  8,  9,  3, 1'b0, 1'b1, 1'b0, 3};
    tbl[3]  = '{2'b10, 2'd0, 2'd2, 0,  0,  8,  9,  2, 1'b1, 1'b1, 1'b0, 2};
    tbl[4]  = '{2'b01, 2'd1, 2'd0, 16, 31, 0,  0,  0, 1'b0, 1'b1, 1'b1, 8};
    tbl[5]  = '{2'b10, 2'd0, 2'd2, 0,  0,  32, 40, 4, 1'b1, 1'b1, 1'b0, 4};
    tbl[6]  = '{2'b01, 2'd1, 2'd0, 50, 60, 0,  0,  8, 1'b0, 1'b1, 1'b0, 8};
    tbl[7]  = '{2'b01, 2'd1, 2'd0, 9,  5,  0,  0,  3, 1'b0, 1'b0, 1'b1, 0};
    tbl[8]  = '{2'b11, 2'd1, 2'd1, 70, 71, 80, 81, 1, 1'b1, 1'b1, 1'b0, 2};
    tbl[9]  = '{2'b01, 2'd1, 2'd1, 70, 71, 80, 81, 2, 1'b0, 1'b1, 1'b0, 2};
    tbl[10] = '{2'b10, 2'd0, 2'd0, 0,  0,  1,  2,  3, 1'b1, 1'b0, 1'b1, 0};
    tbl[11] = '{2'b01, 2'd2, 2'd0, 5,  5,  0,  0,  3, 1'b0, 1'b1, 1'b0, 3};

    // reset with hot inputs: everything must stay quiet
    #1 rst_ni = 1'b0;
    post(0, 2'd1, 32'd0, 32'd3);
    post(1, 2'd2, 32'd4, 32'd8);
    drive_pending();
    drive_noise();
    mem_task_finished_i = 1'b1;
    repeat (3) @(negedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    p_valid = '0;
    drive_pending();
    mem_task_finished_i = 1'b0;
    rst_ni = 1'b1;
    ptr_m = 1'b0;

    // directed table
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].valid[0]) post(0, tbl[i].cmd0, tbl[i].s0, tbl[i].e0);
      if (tbl[i].valid[1]) post(1, tbl[i].cmd1, tbl[i].s1, tbl[i].e1);
      serve(tbl[i].exp_g, tbl[i].exp_legal, tbl[i].exp_err, tbl[i].exp_kend,
            tbl[i].fd, $sformatf("row%0d", i));
    end
    idle_cycles(2);

    // reset asserted in the middle of BUSY
    post(0, 2'd1, 32'h100, 32'h1ff);
    @(negedge clk);
    drive_pending();
    drive_noise();
    mem_task_finished_i = 1'b0;
    @(negedge clk);
    p_valid[0] = 1'b0;
    drive_pending();
    repeat (2) @(negedge clk);
    req_data_write_i[0] = 16'h5a5a;
    #1 check("rst/busy_before", 64'(mem_data_write_o), 64'h5a5a);
    #1 rst_ni = 1'b0;
    post(1, 2'd2, 32'h20, 32'h30);
    drive_pending();
    mem_data_read_i = '1;
    mem_data_read_valid_i = 1'b1;
    mem_data_write_ready_i = 1'b1;
    mem_task_finished_i = 1'b1;
    #1 check_all_zero("rst_async");
    @(negedge clk);
    #1 check_all_zero("rst_hold");
    p_valid = '0;
    drive_pending();
    mem_task_finished_i = 1'b0;
    rst_ni = 1'b1;
    ptr_m = 1'b0;
    post(1, 2'd2, 32'h20, 32'h30);
    serve(1'b1, 1'b1, 1'b0, 3, 3, "post_rst");

    // randomized transactions against the model
    for (int t = 0; t < 150; t++) begin
      for (int r = 0; r < 2; r++) begin
        if (!p_valid[r] && $urandom_range(0, 2) != 0) post_random(r);
      end
      if (p_valid == 2'b00) post_random(int'($urandom_range(0, 1)));
      fd = int'($urandom_range(0, 10));
      model(fd, g, legal, err, kend);
      serve(g, legal, err, kend, fd, $sformatf("rand%0d", t));
      if (p_valid == 2'b00 && $urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
